// File: rtl/johnson_decoder.sv
// Decodes 4-bit Johnson codes to a 0..7 position and tracks succession lock.
// Define JDEC_ERRCNT_EN to build the saturating illegal/seq_err event counter.
module johnson_decoder #(
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       code_in,
    input  logic             code_valid,
    output logic [2:0]       index,
    output logic             index_valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned CODE_W = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CODE_W-1:0]  samp_code_q, samp_code_d;
    logic               samp_vld_q, samp_vld_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [IDX_W-1:0]   ref_q, ref_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               index_valid_q, index_valid_d;
    logic               illegal_q, illegal_d;
    logic               seq_err_q, seq_err_d;
    logic               locked_q, locked_d;

    logic               legal_c;
    logic [IDX_W-1:0]   dec_idx_c;
    logic [IDX_W-1:0]   expect_c;
    logic [CNT_W:0]     cnt_inc_c;

    // Input sample stage: code_in is captured only when code_valid is high.
    always_comb begin
        samp_vld_d  = code_valid;
        samp_code_d = code_valid ? code_in : samp_code_q;
    end

    // Johnson code lookup.
    always_comb begin
        legal_c   = 1'b1;
        dec_idx_c = '0;
        case (samp_code_q)
            4'b0000: dec_idx_c = 3'd0;
            4'b1000: dec_idx_c = 3'd1;
            4'b1100: dec_idx_c = 3'd2;
            4'b1110: dec_idx_c = 3'd3;
            4'b1111: dec_idx_c = 3'd4;
            4'b0111: dec_idx_c = 3'd5;
            4'b0011: dec_idx_c = 3'd6;
            4'b0001: dec_idx_c = 3'd7;
            default: legal_c   = 1'b0;
        endcase
    end

    assign expect_c  = ref_q + IDX_W'(1);
    assign cnt_inc_c = {1'b0, match_cnt_q} + (CNT_W + 1)'(1);

    // Next-state and registered output logic.
    always_comb begin
        state_d       = state_q;
        match_cnt_d   = match_cnt_q;
        ref_d         = ref_q;
        index_d       = index_q;
        index_valid_d = 1'b0;
        illegal_d     = 1'b0;
        seq_err_d     = 1'b0;

        if (samp_vld_q) begin
            index_valid_d = 1'b1;
            illegal_d     = ~legal_c;
            if (legal_c) begin
                index_d = dec_idx_c;
            end
            case (state_q)
                ST_SEARCH: begin
                    if (legal_c) begin
                        ref_d       = dec_idx_c;
                        match_cnt_d = '0;
                        state_d     = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (!legal_c) begin
                        state_d = ST_SEARCH;
                    end else if (dec_idx_c == expect_c) begin
                        match_cnt_d = cnt_inc_c[CNT_W-1:0];
                        ref_d       = dec_idx_c;
                        if (cnt_inc_c >= (CNT_W + 1)'(LOCK_CNT)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        ref_d       = dec_idx_c;
                        match_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (legal_c && (dec_idx_c == expect_c)) begin
                        ref_d = dec_idx_c;
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = ST_SEARCH;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_SEARCH;
            samp_code_q   <= '0;
            samp_vld_q    <= 1'b0;
            match_cnt_q   <= '0;
            ref_q         <= '0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            samp_code_q   <= samp_code_d;
            samp_vld_q    <= samp_vld_d;
            match_cnt_q   <= match_cnt_d;
            ref_q         <= ref_d;
            index_q       <= index_d;
            index_valid_q <= index_valid_d;
            illegal_q     <= illegal_d;
            seq_err_q     <= seq_err_d;
            locked_q      <= locked_d;
        end
    end

    assign index       = index_q;
    assign index_valid = index_valid_q;
    assign illegal     = illegal_q;
    assign seq_err     = seq_err_q;
    assign locked      = locked_q;

`ifdef JDEC_ERRCNT_EN
    logic [ERR_W-1:0] err_q, err_d;

    // One count per erroneous sample, saturating at all-ones.
    always_comb begin
        err_d = err_q;
        if ((illegal_d || seq_err_d) && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Randomised self-checking bench for johnson_decoder against a behavioural model.
module tb_johnson_decoder;

    localparam int unsigned LOCK_CNT = 2;
    localparam int unsigned ERR_W    = 8;
`ifdef JDEC_ERRCNT_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       code_in = 4'd0;
    logic             code_valid = 1'b0;
    logic [2:0]       index;
    logic             index_valid;
    logic             illegal;
    logic             seq_err;
    logic             locked;
    logic [ERR_W-1:0] err_count;

    johnson_decoder #(.LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
        .index(index), .index_valid(index_valid), .illegal(illegal),
        .seq_err(seq_err), .locked(locked), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [3:0] jcode [8];
    initial begin
        jcode[0] = 4'b0000; jcode[1] = 4'b1000; jcode[2] = 4'b1100; jcode[3] = 4'b1110;
        jcode[4] = 4'b1111; jcode[5] = 4'b0111; jcode[6] = 4'b0011; jcode[7] = 4'b0001;
    end

    function automatic int lookup(input logic [3:0] c);
        for (int i = 0; i < 8; i++) if (jcode[i] == c) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a sample seen at one edge shows on the outputs one edge later.
    int m_index, m_iv, m_ill, m_seq, m_locked, m_err;
    int m_have_ref, m_ref, m_run;
    bit p_vld;
    logic [3:0] p_code;

    task automatic model_step(input bit v, input logic [3:0] c);
        int idx;
        m_iv = 0; m_ill = 0; m_seq = 0;
        if (!v) return;
        idx  = lookup(c);
        m_iv = 1;
        m_ill = (idx < 0);
        if (idx >= 0) m_index = idx;
        if (m_locked != 0) begin
            if (idx == (m_ref + 1) % 8) m_ref = idx;
            else begin m_seq = 1; m_locked = 0; m_have_ref = 0; end
        end else if (m_have_ref != 0) begin
            if (idx < 0) m_have_ref = 0;
            else if (idx == (m_ref + 1) % 8) begin
                m_run++; m_ref = idx;
                if (m_run >= int'(LOCK_CNT)) m_locked = 1;
            end else begin m_ref = idx; m_run = 0; end
        end else if (idx >= 0) begin
            m_have_ref = 1; m_ref = idx; m_run = 0;
        end
        if (ERR_ON && (m_ill != 0 || m_seq != 0) && m_err < (1 << ERR_W) - 1) m_err++;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_index = 0; m_iv = 0; m_ill = 0; m_seq = 0; m_locked = 0; m_err = 0;
            m_have_ref = 0; m_ref = 0; m_run = 0; p_vld = 1'b0; p_code = 4'd0;
        end else begin
            model_step(p_vld, p_code);
            p_vld  = code_valid;
            p_code = code_in;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("index",       int'(index),       m_index);
            chk("index_valid", int'(index_valid), m_iv);
            chk("illegal",     int'(illegal),     m_ill);
            chk("seq_err",     int'(seq_err),     m_seq);
            chk("locked",      int'(locked),      m_locked);
            chk("err_count",   int'(err_count),   m_err);
        end
    end

    task automatic drive(input bit v, input logic [3:0] c);
        @(negedge clk);
        code_valid = v;
        code_in    = c;
    endtask

    // Drive one code, then idle so its result is on the outputs at the next negedge.
    task automatic drive_settle(input logic [3:0] c);
        drive(1'b1, c);
        drive(1'b0, 4'd0);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_index"}, int'(index), 0);
        chk({tag, "_iv"},    int'(index_valid), 0);
        chk({tag, "_ill"},   int'(illegal), 0);
        chk({tag, "_seq"},   int'(seq_err), 0);
        chk({tag, "_lock"},  int'(locked), 0);
        chk({tag, "_err"},   int'(err_count), 0);
    endtask

    logic [3:0] full_seq [9];
    int last_idx;

    initial begin
        full_seq[0] = 4'b0001; full_seq[1] = 4'b0000; full_seq[2] = 4'b1000;
        full_seq[3] = 4'b1100; full_seq[4] = 4'b1110; full_seq[5] = 4'b1111;
        full_seq[6] = 4'b0111; full_seq[7] = 4'b0011; full_seq[8] = 4'b0001;

        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        #1 rst = 1'b1;

        // Full Johnson cycle locks after the third sample and ends at index 7.
        for (int i = 0; i < 9; i++) drive(1'b1, full_seq[i]);
        drive(1'b0, 4'd0);
        @(negedge clk);
        chk("seq_index", int'(index), 7);
        chk("seq_locked", int'(locked), 1);
        chk("seq_err_cnt", int'(err_count), 0);

        // Five idle cycles, then the correct successor keeps the lock.
        repeat (5) drive(1'b0, 4'd0);
        drive_settle(4'b0000);
        chk("gap_locked", int'(locked), 1);
        chk("gap_index", int'(index), 0);

        // Illegal code while locked at 4 raises both pulses.
        drive(1'b1, 4'b1000); drive(1'b1, 4'b1100); drive(1'b1, 4'b1110);
        drive_settle(4'b1111);
        chk("at4_locked", int'(locked), 1);
        drive_settle(4'b1010);
        chk("ill_illegal", int'(illegal), 1);
        chk("ill_seq", int'(seq_err), 1);
        chk("ill_index", int'(index), 4);
        chk("ill_locked", int'(locked), 0);
        chk("ill_err", int'(err_count), ERR_ON ? 1 : 0);

        // Out-of-sequence legal code while locked at 2.
        drive(1'b1, 4'b0000); drive(1'b1, 4'b1000);
        drive_settle(4'b1100);
        chk("at2_locked", int'(locked), 1);
        drive_settle(4'b1111);
        chk("oos_seq", int'(seq_err), 1);
        chk("oos_illegal", int'(illegal), 0);
        chk("oos_index", int'(index), 4);
        chk("oos_locked", int'(locked), 0);

        // Asynchronous reset while locked clears outputs immediately.
        drive(1'b1, 4'b0000); drive(1'b1, 4'b1000);
        drive_settle(4'b1100);
        chk("prerst_locked", int'(locked), 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_vals("arst");
        @(negedge clk);
        #1 rst = 1'b1;
        drive(1'b1, 4'b0011);
        drive_settle(4'b0001);
        chk("post_rst_nolock", int'(locked), 0);
        chk("post_rst_index", int'(index), 7);
        drive_settle(4'b0000);
        chk("post_rst_lock", int'(locked), 1);

        // Counter saturation under a long run of illegal codes.
        for (int i = 0; i < 300; i++) drive(1'b1, 4'b1010);
        drive(1'b0, 4'd0);
        @(negedge clk);
        chk("sat_err", int'(err_count), ERR_ON ? 255 : 0);

        // Randomised mix of successors, random legal codes and arbitrary codes.
        last_idx = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            int sel;
            logic [3:0] c;
            r   = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 7));
            if (sel < 4)      c = jcode[(last_idx + 1) % 8];
            else if (sel < 6) c = jcode[$urandom_range(0, 7)];
            else if (sel < 7) c = jcode[last_idx];
            else              c = 4'($urandom_range(0, 15));
            if (r != 0 && lookup(c) >= 0) last_idx = lookup(c);
            drive(r != 0, c);
        end
        drive(1'b0, 4'd0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
